pixel_pair_proc: RTL and testbench

- Point-operation image processing stage sitting directly upstream of the BMP write stage.
- Accepts two RGB pixels (even/odd) per clock from the image read stage.
- Applies a per-frame selected point operation, then drives hsync plus the six DATA_WRITE_* bytes into the writer.
- Counts pixel pairs per frame and raises Write_Done once the last pair of the frame has been emitted.

---
 rtl/pixel_pair_proc_if.sv | 39 +++
 rtl/pixel_pair_proc.sv | 169 ++++++++++++++++
 tb/tb_pixel_pair_proc.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pixel_pair_proc_if.sv
// Bus between the image-read stage, pixel_pair_proc and the BMP writer.
// The `invert` control exists only when PIXEL_PROC_INVERT_EN is defined.
interface pixel_pair_proc_if #(parameter int CNT_W = 16);
  logic             frame_start;
  logic [1:0]       mode;
  logic [7:0]       value;
`ifdef PIXEL_PROC_INVERT_EN
  logic             invert;
`endif
  logic             in_valid;
  logic [7:0]       R0_IN, G0_IN, B0_IN, R1_IN, G1_IN, B1_IN;
  logic             hsync;
  logic [7:0]       DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0;
  logic [7:0]       DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1;
  logic [CNT_W-1:0] col_cnt, row_cnt;
  logic             Write_Done, overrun;

  modport master (
    output frame_start, mode, value,
`ifdef PIXEL_PROC_INVERT_EN
    output invert,
`endif
    output in_valid, R0_IN, G0_IN, B0_IN, R1_IN, G1_IN, B1_IN,
    input  hsync, DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
    input  DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1,
    input  col_cnt, row_cnt, Write_Done, overrun
  );

  modport slave (
    input  frame_start, mode, value,
`ifdef PIXEL_PROC_INVERT_EN
    input  invert,
`endif
    input  in_valid, R0_IN, G0_IN, B0_IN, R1_IN, G1_IN, B1_IN,
    output hsync, DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
    output DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1,
    output col_cnt, row_cnt, Write_Done, overrun
  );
endinterface

// File: rtl/pixel_pair_proc.sv
// Two-pixel-per-clock point-operation stage feeding the BMP writer.
// Define PIXEL_PROC_INVERT_EN to add the per-frame `invert` output stage.

module pp_lane #(parameter int VEC_W = 8) (
  input  logic [1:0]       mode_i,
  input  logic [VEC_W-1:0] value_i,
`ifdef PIXEL_PROC_INVERT_EN
  input  logic             invert_i,
`endif
  input  logic [VEC_W-1:0] pix_i,
  output logic [VEC_W-1:0] pix_o
);
  logic [VEC_W:0]   sum, diff;
  logic [VEC_W-1:0] res;

  // Carry/borrow in the extra bit drives saturation.
  assign sum  = {1'b0, pix_i} + {1'b0, value_i};
  assign diff = {1'b0, pix_i} - {1'b0, value_i};

  always_comb begin
    res = pix_i;
    case (mode_i)
      2'd1:    res = sum[VEC_W]  ? '1 : sum[VEC_W-1:0];
      2'd2:    res = diff[VEC_W] ? '0 : diff[VEC_W-1:0];
      2'd3:    res = (pix_i >= value_i) ? '1 : '0;
      default: res = pix_i;
    endcase
`ifdef PIXEL_PROC_INVERT_EN
    pix_o = invert_i ? ~res : res;
`else
    pix_o = res;
`endif
  end
endmodule

module pixel_pair_proc #(
  parameter int WIDTH  = 500,
  parameter int HEIGHT = 500,
  parameter int CNT_W  = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  pixel_pair_proc_if.slave bus
);
  localparam int NUM_LANES = 6;
  localparam int VEC_W     = 8;
  localparam int STAGES    = 2;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(WIDTH/2 - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef struct packed {
    logic [1:0]       mode;
    logic [VEC_W-1:0] value;
`ifdef PIXEL_PROC_INVERT_EN
    logic             inv;
`endif
  } cfg_t;

  state_e state_q, state_d;
  cfg_t   cfg_q, cfg_d;
  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  logic [NUM_LANES-1:0][VEC_W-1:0] in_pix, s1_pix_q, s1_pix_d, s2_res, out_pix_q, out_pix_d;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  logic ovr_q, ovr_d;
  logic accept, last_out, write_done, drop;

  // Lane order: R0, G0, B0, R1, G1, B1.
  assign in_pix = {bus.B1_IN, bus.G1_IN, bus.R1_IN, bus.B0_IN, bus.G0_IN, bus.R0_IN};

  // A row ends when the emitted pair just wrapped col back to 0.
  assign last_out = vld_pipe_q[STAGES] && (col_q == '0) && (row_q == ROW_LAST);

  // FSM: state register
  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (bus.frame_start) state_d = RUN;
    else begin
      case (state_q)
        RUN:     if (last_out) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    accept     = bus.in_valid && (bus.frame_start || state_q == RUN);
    drop       = bus.in_valid && !bus.frame_start && state_q == DONE;
    write_done = (state_q == DONE);
  end

  always_comb begin
    cfg_d = cfg_q;
    if (bus.frame_start) begin
      cfg_d.mode  = bus.mode;
      cfg_d.value = bus.value;
`ifdef PIXEL_PROC_INVERT_EN
      cfg_d.inv   = bus.invert;
`endif
    end
    // frame_start kills whatever sits in stage 1; a same-cycle pair still enters.
    vld_pipe_d[1]      = accept;
    vld_pipe_d[STAGES] = vld_pipe_q[1] && !bus.frame_start;
    s1_pix_d  = accept ? in_pix : s1_pix_q;
    out_pix_d = vld_pipe_d[STAGES] ? s2_res : out_pix_q;
    col_d = col_q;
    row_d = row_q;
    ovr_d = ovr_q | drop;
    if (bus.frame_start) begin
      col_d = '0;
      row_d = '0;
      ovr_d = 1'b0;
    end else begin
      if (vld_pipe_d[STAGES]) col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
      if (vld_pipe_q[STAGES] && col_q == '0) row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pp_lane #(.VEC_W(VEC_W)) u_lane (
      .mode_i   (cfg_q.mode),
      .value_i  (cfg_q.value),
`ifdef PIXEL_PROC_INVERT_EN
      .invert_i (cfg_q.inv),
`endif
      .pix_i    (s1_pix_q[l]),
      .pix_o    (s2_res[l])
    );
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cfg_q      <= '0;
      vld_pipe_q <= '0;
      s1_pix_q   <= '0;
      out_pix_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      vld_pipe_q <= vld_pipe_d;
      s1_pix_q   <= s1_pix_d;
      out_pix_q  <= out_pix_d;
      col_q      <= col_d;
      row_q      <= row_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.hsync         = vld_pipe_q[STAGES];
  assign bus.DATA_WRITE_R0 = out_pix_q[0];
  assign bus.DATA_WRITE_G0 = out_pix_q[1];
  assign bus.DATA_WRITE_B0 = out_pix_q[2];
  assign bus.DATA_WRITE_R1 = out_pix_q[3];
  assign bus.DATA_WRITE_G1 = out_pix_q[4];
  assign bus.DATA_WRITE_B1 = out_pix_q[5];
  assign bus.col_cnt       = col_q;
  assign bus.row_cnt       = row_q;
  assign bus.Write_Done    = write_done;
  assign bus.overrun       = ovr_q;
endmodule

// File: tb/tb_pixel_pair_proc.sv
// Directed bench for pixel_pair_proc with a 4x2 image (4 pairs per frame).
module tb_pixel_pair_proc;
  logic HCLK = 1'b0;
  logic HRESET;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   hs_cnt = 0;
  int   snap;
  int   ec[4] = '{1, 0, 1, 0};
  int   er[4] = '{0, 0, 1, 1};

  pixel_pair_proc_if #(.CNT_W(16)) bus ();

  pixel_pair_proc #(.WIDTH(4), .HEIGHT(2), .CNT_W(16)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) if (bus.hsync === 1'b1) hs_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic px(input logic [7:0] r0, g0, b0, r1, g1, b1);
    bus.R0_IN = r0; bus.G0_IN = g0; bus.B0_IN = b0;
    bus.R1_IN = r1; bus.G1_IN = g1; bus.B1_IN = b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    HRESET = 1'b1;
    bus.frame_start = 1'b0; bus.mode = 2'd0; bus.value = 8'd0; bus.in_valid = 1'b0;
`ifdef PIXEL_PROC_INVERT_EN
    bus.invert = 1'b0;
`endif
    px(9, 9, 9, 9, 9, 9);

    // 1: reset, then in_valid without frame_start is ignored
    tick; tick;
    HRESET = 1'b0; bus.in_valid = 1'b1;
    chk("rst_hsync", bus.hsync, 0);
    chk("rst_r0", bus.DATA_WRITE_R0, 0);
    chk("rst_b1", bus.DATA_WRITE_B1, 0);
    chk("rst_col", bus.col_cnt, 0);
    chk("rst_row", bus.row_cnt, 0);
    chk("rst_wd", bus.Write_Done, 0);
    chk("rst_ovr", bus.overrun, 0);
    snap = hs_cnt;
    repeat (4) tick;
    chk("idle_no_hsync", hs_cnt - snap, 0);
    chk("idle_wd", bus.Write_Done, 0);
    chk("idle_r0", bus.DATA_WRITE_R0, 0);

    // 2: brighten, saturating
    bus.frame_start = 1'b1; bus.mode = 2'd1; bus.value = 8'd50;
    px(220, 10, 0, 200, 205, 255);
    tick;
    bus.frame_start = 1'b0; bus.in_valid = 1'b0;
    chk("lat1_hsync", bus.hsync, 0);
    tick;
    chk("br_hsync", bus.hsync, 1);
    chk("br_r0", bus.DATA_WRITE_R0, 255);
    chk("br_g0", bus.DATA_WRITE_G0, 60);
    chk("br_b0", bus.DATA_WRITE_B0, 50);
    chk("br_r1", bus.DATA_WRITE_R1, 250);
    chk("br_g1", bus.DATA_WRITE_G1, 255);
    chk("br_b1", bus.DATA_WRITE_B1, 255);
    chk("br_col", bus.col_cnt, 1);
    chk("br_row", bus.row_cnt, 0);

    // mid-frame mode/value changes are ignored
    bus.mode = 2'd3; bus.value = 8'd0; bus.in_valid = 1'b1;
    px(100, 0, 0, 0, 0, 0);
    tick;
    bus.in_valid = 1'b0;
    chk("hold_hsync0", bus.hsync, 0);
    chk("hold_r0", bus.DATA_WRITE_R0, 255);
    tick;
    chk("shadow_hsync", bus.hsync, 1);
    chk("shadow_r0", bus.DATA_WRITE_R0, 150);
    chk("shadow_g0", bus.DATA_WRITE_G0, 50);
    chk("shadow_col", bus.col_cnt, 0);

    // 3: darken, clamping at 0
    bus.frame_start = 1'b1; bus.mode = 2'd2; bus.value = 8'd30; bus.in_valid = 1'b1;
    px(20, 100, 30, 29, 255, 31);
    tick;
    bus.frame_start = 1'b0; bus.in_valid = 1'b0;
    chk("fs_col_clr", bus.col_cnt, 0);
    chk("fs_row_clr", bus.row_cnt, 0);
    tick;
    chk("dk_hsync", bus.hsync, 1);
    chk("dk_r0", bus.DATA_WRITE_R0, 0);
    chk("dk_g0", bus.DATA_WRITE_G0, 70);
    chk("dk_b0", bus.DATA_WRITE_B0, 0);
    chk("dk_r1", bus.DATA_WRITE_R1, 0);
    chk("dk_g1", bus.DATA_WRITE_G1, 225);
    chk("dk_b1", bus.DATA_WRITE_B1, 1);

    // threshold
    bus.frame_start = 1'b1; bus.mode = 2'd3; bus.value = 8'd128; bus.in_valid = 1'b1;
    px(127, 128, 0, 255, 129, 1);
    tick;
    bus.frame_start = 1'b0; bus.in_valid = 1'b0;
    tick;
    chk("th_hsync", bus.hsync, 1);
    chk("th_r0", bus.DATA_WRITE_R0, 0);
    chk("th_g0", bus.DATA_WRITE_G0, 255);
    chk("th_b0", bus.DATA_WRITE_B0, 0);
    chk("th_r1", bus.DATA_WRITE_R1, 255);
    chk("th_g1", bus.DATA_WRITE_G1, 255);
    chk("th_b1", bus.DATA_WRITE_B1, 0);

    // 4: full frame, pass-through, back to back
    for (int k = 0; k < 6; k++) begin
      bus.frame_start = (k == 0); bus.mode = 2'd0; bus.value = 8'd77;
      bus.in_valid = (k < 4);
      px(8'(16*k + 1), 0, 0, 0, 0, 8'(200 + k));
      tick;
      if (k >= 1 && k <= 4) begin
        chk("ff_hsync", bus.hsync, 1);
        chk("ff_col", bus.col_cnt, ec[k-1]);
        chk("ff_row", bus.row_cnt, er[k-1]);
        chk("ff_r0", bus.DATA_WRITE_R0, 16*(k-1) + 1);
        chk("ff_b1", bus.DATA_WRITE_B1, 200 + k - 1);
        chk("ff_wd", bus.Write_Done, 0);
      end else if (k == 0) begin
        chk("ff_hsync0", bus.hsync, 0);
      end else begin
        chk("done_hsync", bus.hsync, 0);
        chk("done_wd", bus.Write_Done, 1);
        chk("done_col", bus.col_cnt, 0);
        chk("done_row", bus.row_cnt, 0);
        chk("done_r0_hold", bus.DATA_WRITE_R0, 49);
      end
    end
    bus.frame_start = 1'b0;
    tick;
    chk("wd_stays", bus.Write_Done, 1);

    // 5: input while DONE -> overrun, no hsync
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    chk("ovr_set", bus.overrun, 1);
    snap = hs_cnt;
    tick; tick;
    chk("ovr_no_hsync", hs_cnt - snap, 0);
    chk("ovr_sticky", bus.overrun, 1);
    chk("ovr_wd", bus.Write_Done, 1);
    bus.frame_start = 1'b1;
    tick;
    bus.frame_start = 1'b0;
    chk("fs_wd_clr", bus.Write_Done, 0);
    chk("fs_ovr_clr", bus.overrun, 0);
    chk("fs_col0", bus.col_cnt, 0);
    chk("fs_row0", bus.row_cnt, 0);

    // 6: frame_start with a pair in flight flushes it
    bus.in_valid = 1'b1; px(5, 0, 0, 0, 0, 0);
    tick;
    px(6, 0, 0, 0, 0, 0);
    tick;
    bus.in_valid = 1'b0; bus.frame_start = 1'b1;
    chk("pre_flush_r0", bus.DATA_WRITE_R0, 5);
    tick;
    bus.frame_start = 1'b0;
    chk("flush_hsync", bus.hsync, 0);
    chk("flush_col", bus.col_cnt, 0);
    chk("flush_row", bus.row_cnt, 0);
    snap = hs_cnt;
    tick; tick;
    chk("flush_no_hsync", hs_cnt - snap, 0);
    chk("flush_r0_hold", bus.DATA_WRITE_R0, 5);

    // HRESET mid-frame
    bus.in_valid = 1'b1; px(7, 0, 0, 0, 0, 0);
    tick;
    HRESET = 1'b1;
    tick;
    HRESET = 1'b0; px(8, 0, 0, 0, 0, 0);
    snap = hs_cnt;
    chk("mrst_r0", bus.DATA_WRITE_R0, 0);
    tick; tick; tick;
    chk("mrst_no_hsync", hs_cnt - snap, 0);
    chk("mrst_wd", bus.Write_Done, 0);
    chk("mrst_col", bus.col_cnt, 0);
    bus.frame_start = 1'b1; bus.mode = 2'd1; bus.value = 8'd1;
    tick;
    bus.frame_start = 1'b0; bus.in_valid = 1'b0;
    chk("restart_lat", bus.hsync, 0);
    tick;
    chk("restart_hsync", bus.hsync, 1);
    chk("restart_r0", bus.DATA_WRITE_R0, 9);
    chk("restart_col", bus.col_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
